int8_32x32_requant: RTL and testbench

// - Downstream stage of the 32x32 int8 matmul wrapper: consumes its 32 x 512-bit C rows (32 int16 lanes/row)
//   and emits 32 x 256-bit rows of requantized int8 (32 lanes/row), ready for the next layer's A/B stream.
// - Per lane: multiply by scale, round, arithmetic shift, add zero-point, saturate. One ap_ctrl_hs-style job = one matrix.

---
 rtl/int8_mm_pkg.sv | 24 ++
 rtl/int8_32x32_requant_if.sv | 13 +
 rtl/requant_lane.sv | 62 ++++++
 rtl/int8_32x32_requant.sv | 115 +++++++++++
 tb/tb_int8_32x32_requant.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/int8_mm_pkg.sv
// Shared constants, FSM state type and shift clamp helper for the int8 32x32 requant stage.
package int8_mm_pkg;

  localparam int unsigned Rows   = 32;
  localparam int unsigned Lanes  = 32;
  localparam int unsigned InW    = 16;
  localparam int unsigned OutW   = 8;
  localparam int unsigned ScaleW = 8;
  localparam int unsigned ShiftW = 5;
  localparam int unsigned CntW   = $clog2(Rows + 1);

  localparam logic [ShiftW-1:0] ShiftMax = ShiftW'(23);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic [ShiftW-1:0] clamp_shift(input logic [ShiftW-1:0] s);
    return (s > ShiftMax) ? ShiftMax : s;
  endfunction

endpackage

// File: rtl/int8_32x32_requant_if.sv
// AXI-Stream style valid/ready row channel; master drives data and valid.
interface int8_32x32_requant_if #(
  parameter int unsigned DataW = 512
) ();

  logic [DataW-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/requant_lane.sv
// One requantization lane: stage 1 multiplies and adds the rounding term, stage 2 shifts,
// offsets and saturates. Build with REQUANT_RELU_EN defined to clamp negatives to zero.
module requant_lane
  import int8_mm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [InW-1:0]    x_i,
  input  logic [ScaleW-1:0] scale_i,
  input  logic [ShiftW-1:0] shift_i,
  input  logic [OutW-1:0]   zp_i,
  output logic [OutW-1:0]   q_o
);

  localparam int unsigned ProdW = InW + ScaleW + 1;
  localparam int unsigned SumW  = ProdW + 1;

  localparam logic signed [SumW-1:0] SatMax = SumW'((1 << (OutW - 1)) - 1);
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  logic signed [ProdW-1:0] prod, p_d, p_q, r;
  logic        [ProdW-1:0] rnd;
  logic signed [SumW-1:0]  s;
  logic        [OutW-1:0]  sat_d, q_q;

  // Scale is unsigned: zero-extend it so the signed multiply treats it as positive.
  always_comb begin
    prod = $signed({{(ProdW - InW){x_i[InW-1]}}, x_i})
         * $signed({{(ProdW - ScaleW){1'b0}}, scale_i});
    rnd  = (shift_i == '0) ? '0 : ({{(ProdW - 1){1'b0}}, 1'b1} << (shift_i - 1'b1));
    p_d  = prod + $signed(rnd);
  end

  always_comb begin
    r = p_q >>> shift_i;
    s = $signed({r[ProdW-1], r}) + $signed({{(SumW - OutW){zp_i[OutW-1]}}, zp_i});
    if (s > SatMax) begin
      sat_d = SatMax[OutW-1:0];
    end else if (s < SatMin) begin
      sat_d = SatMin[OutW-1:0];
    end else begin
      sat_d = s[OutW-1:0];
    end
`ifdef REQUANT_RELU_EN
    if (sat_d[OutW-1]) sat_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q <= '0;
      q_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
      q_q <= sat_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/int8_32x32_requant.sv
// Requantizes 32 rows of 32 int16 lanes into int8 rows under an ap_ctrl_hs job handshake.
// Optional macro REQUANT_RELU_EN (in requant_lane) restricts outputs to [0,127].
module int8_32x32_requant
  import int8_mm_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_ce,
  input  logic                 ap_start,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 ap_done,
  input  logic                 ap_continue,
  input  logic [ScaleW-1:0]    scale,
  input  logic [ShiftW-1:0]    shift,
  input  logic [OutW-1:0]      zero_point,
  int8_32x32_requant_if.slave  c_if,
  int8_32x32_requant_if.master q_if
);

  localparam logic [CntW-1:0] RowsCnt = CntW'(Rows);

  state_e               state_q, state_d;
  logic [CntW-1:0]      rows_in_q, rows_in_d, rows_out_q, rows_out_d;
  logic [ScaleW-1:0]    scale_q;
  logic [ShiftW-1:0]    shift_q;
  logic [OutW-1:0]      zp_q;
  logic                 v1_q, v2_q, q_valid_q;
  logic [Lanes*OutW-1:0] lane_q, q_data_q;
  logic                 adv, step, c_fire, q_fire, start;

  // Whole pipeline moves as one; an unaccepted output row freezes every stage.
  assign adv         = ~q_valid_q | q_if.tready;
  assign step        = ap_ce & adv;
  assign c_if.tready = ap_ce & (state_q == StRun) & (rows_in_q < RowsCnt) & adv;
  assign c_fire      = c_if.tready & c_if.tvalid;
  assign q_fire      = ap_ce & q_valid_q & q_if.tready;
  assign start       = (state_q == StIdle) & ap_start;

  always_comb begin
    state_d    = state_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d    = StRun;
          rows_in_d  = '0;
          rows_out_d = '0;
        end
      end
      StRun: begin
        if (c_fire) rows_in_d = rows_in_q + 1'b1;
        if (q_fire) begin
          rows_out_d = rows_out_q + 1'b1;
          if (rows_out_q == RowsCnt - 1'b1) state_d = StDone;
        end
      end
      StDone: begin
        if (ap_continue) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      zp_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      q_valid_q  <= 1'b0;
      q_data_q   <= '0;
    end else if (ap_ce) begin
      state_q    <= state_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      if (start) begin
        scale_q <= scale;
        shift_q <= clamp_shift(shift);
        zp_q    <= zero_point;
      end
      if (adv) begin
        v1_q      <= c_fire;
        v2_q      <= v1_q;
        q_valid_q <= v2_q;
        q_data_q  <= lane_q;
      end
    end
  end

  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    requant_lane u_lane (
      .clk_i   (ap_clk),
      .rst_i   (ap_rst),
      .en_i    (step),
      .x_i     (c_if.tdata[k*InW +: InW]),
      .scale_i (scale_q),
      .shift_i (shift_q),
      .zp_i    (zp_q),
      .q_o     (lane_q[k*OutW +: OutW])
    );
  end

  assign ap_idle      = (state_q == StIdle);
  assign ap_ready     = (state_q == StIdle);
  assign ap_done      = (state_q == StDone);
  assign q_if.tvalid  = q_valid_q;
  assign q_if.tdata   = q_data_q;

endmodule

// File: tb/tb_int8_32x32_requant.sv
// Bench for int8_32x32_requant: fixed-vector jobs, randomized jobs against an integer model,
// job-boundary and mid-job reset sequences.
module tb_int8_32x32_requant;

  localparam int NR = 32;
  localparam int NL = 32;

  typedef struct {
    int sc;
    int sh;
    int zp;
    int x;
    int e;
  } vec_t;

  logic       ap_clk = 1'b0;
  logic       ap_rst, ap_ce, ap_start, ap_continue;
  logic       ap_idle, ap_ready, ap_done;
  logic [7:0] scale, zero_point;
  logic [4:0] shift;

  int checks   = 0;
  int failures = 0;

  logic [511:0] in_rows [NR];

  int8_32x32_requant_if #(.DataW(512)) c_if ();
  int8_32x32_requant_if #(.DataW(256)) q_if ();

  int8_32x32_requant dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_ce       (ap_ce),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .scale       (scale),
    .shift       (shift),
    .zero_point  (zero_point),
    .c_if        (c_if.slave),
    .q_if        (q_if.master)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Integer reference: exact product, half-up rounding, floor shift, offset, saturate.
  function automatic logic [7:0] ref_q(input int x, input int sc, input int sh, input int zp);
    longint p;
    int     s;
    s = (sh > 23) ? 23 : sh;
    p = longint'(x) * longint'(sc);
    if (s > 0) p = p + (longint'(1) << (s - 1));
    p = p >>> s;
    p = p + zp;
    if (p > 127) p = 127;
    else if (p < -128) p = -128;
`ifdef REQUANT_RELU_EN
    if (p < 0) p = 0;
`endif
    return p[7:0];
  endfunction

  function automatic logic [255:0] model_row(input logic [511:0] r, input int sc, input int sh,
                                             input int zp);
    logic [255:0] o;
    for (int k = 0; k < NL; k++) begin
      o[k*8 +: 8] = ref_q(int'($signed(r[k*16 +: 16])), sc, sh, zp);
    end
    return o;
  endfunction

  task automatic run_job(input string tag, input int sc, input int sh, input int zp,
                         input int duty, input int vduty, input bit ce_jit, input bit chk_lat,
                         input bit use_fix, input logic [255:0] fix_row);
    logic [255:0] exp_q[$];
    logic [255:0] prev_data, want;
    bit  prev_stall = 0;
    int  n_in = 0, n_out = 0, cyc = 0, first_in = -1, first_out = -1;

    scale = 8'(sc); shift = 5'(sh); zero_point = 8'(zp); ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    // Scrambled after start so a job that re-reads the inputs produces wrong rows.
    scale = ~scale; shift = ~shift; zero_point = ~zero_point;
    check({tag, "_idle_in_run"}, ap_idle, 1'b0);

    while (!ap_done && cyc < 3000) begin
      ap_ce       = ce_jit ? ($urandom_range(99) >= 10) : 1'b1;
      ap_start    = 1'($urandom_range(1));
      ap_continue = 1'b1;
      c_if.tvalid = (n_in < NR) && ($urandom_range(99) < vduty);
      if (n_in < NR) c_if.tdata = in_rows[n_in];
      q_if.tready = ap_ce && ($urandom_range(99) < duty);
      #1;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, q_if.tvalid, 1'b1);
        check({tag, "_stall_data"}, q_if.tdata, prev_data);
      end
      if (c_if.tvalid && c_if.tready) begin
        exp_q.push_back(use_fix ? fix_row : model_row(in_rows[n_in], sc, sh, zp));
        if (first_in < 0) first_in = cyc;
        n_in++;
      end
      if (q_if.tvalid && first_out < 0) first_out = cyc;
      if (q_if.tvalid && q_if.tready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~q_if.tdata;
        check($sformatf("%s_row%0d", tag, n_out), q_if.tdata, want);
        n_out++;
      end
      prev_stall = q_if.tvalid && !q_if.tready;
      prev_data  = q_if.tdata;
      @(posedge ap_clk); #1;
      cyc++;
    end
    ap_continue = 1'b0; ap_start = 1'b0; ap_ce = 1'b1;

    check({tag, "_done"}, ap_done, 1'b1);
    check({tag, "_rows_out"}, 256'(n_out), 256'(NR));
    if (chk_lat) check({tag, "_latency"}, 256'(first_out - first_in), 256'd3);

    // Extra beat after the last row must be refused; DONE must persist.
    for (int i = 0; i < 3; i++) begin
      c_if.tvalid = 1'b1; c_if.tdata = in_rows[0]; q_if.tready = 1'b1;
      #1;
      check({tag, "_extra_beat_tready"}, c_if.tready, 1'b0);
      check({tag, "_done_hold"}, ap_done, 1'b1);
      check({tag, "_done_qvalid"}, q_if.tvalid, 1'b0);
      @(posedge ap_clk); #1;
    end
    c_if.tvalid = 1'b0;
    ap_continue = 1'b1;
    @(posedge ap_clk); #1;
    ap_continue = 1'b0;
    check({tag, "_back_idle"}, ap_idle, 1'b1);
    check({tag, "_done_clear"}, ap_done, 1'b0);
  endtask

  initial begin
    vec_t         vecs[14];
    logic [15:0]  xv;
    logic [7:0]   ev;
    int           e, n, guard;

    vecs[0]  = '{1, 0, 0, 100, 100};
    vecs[1]  = '{1, 0, 0, -100, -100};
    vecs[2]  = '{1, 0, 0, 300, 127};
    vecs[3]  = '{1, 0, 0, -300, -128};
    vecs[4]  = '{1, 1, 0, 3, 2};
    vecs[5]  = '{1, 1, 0, -3, -1};
    vecs[6]  = '{1, 1, 0, 5, 3};
    vecs[7]  = '{255, 8, 0, 256, 127};
    vecs[8]  = '{1, 0, -10, 5, -5};
    vecs[9]  = '{1, 0, 100, 50, 127};
    vecs[10] = '{255, 31, 0, 32767, 1};
    vecs[11] = '{255, 0, 0, -32768, -128};
    vecs[12] = '{200, 4, -5, -7, -92};
    vecs[13] = '{0, 3, -128, 1234, -128};

    ap_rst = 1'b1; ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    scale = '0; shift = '0; zero_point = '0;
    c_if.tvalid = 1'b0; c_if.tdata = '0; q_if.tready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    #1;
    check("rst_idle", ap_idle, 1'b1);
    check("rst_ready", ap_ready, 1'b1);
    check("rst_done", ap_done, 1'b0);
    check("rst_qvalid", q_if.tvalid, 1'b0);
    check("rst_qdata", q_if.tdata, '0);
    check("rst_ctready", c_if.tready, 1'b0);

    for (int i = 0; i < 14; i++) begin
      xv = 16'(vecs[i].x);
      for (int r = 0; r < NR; r++) in_rows[r] = {NL{xv}};
      e = vecs[i].e;
`ifdef REQUANT_RELU_EN
      if (e < 0) e = 0;
`endif
      ev = 8'(e);
      run_job($sformatf("vec%0d", i), vecs[i].sc, vecs[i].sh, vecs[i].zp,
              100, 100, 1'b0, 1'b1, 1'b1, {NL{ev}});
    end

    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < NR; r++) begin
        for (int k = 0; k < NL; k++) in_rows[r][k*16 +: 16] = 16'($urandom);
      end
      run_job($sformatf("rnd%0d", j), int'($urandom_range(255)),
              (j == 3) ? int'($urandom_range(31)) : int'($urandom_range(10)),
              int'($urandom_range(255)) - 128, 30, 80, 1'(j % 2), 1'b0, 1'b0, '0);
    end

    // Reset after ten rows have been accepted.
    for (int r = 0; r < NR; r++) in_rows[r] = {16{32'($urandom)}};
    scale = 8'd3; shift = 5'd2; zero_point = 8'd0; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; q_if.tready = 1'b1; n = 0; guard = 0;
    while (n < 10 && guard < 200) begin
      c_if.tvalid = 1'b1; c_if.tdata = in_rows[n];
      #1;
      if (c_if.tready) n++;
      @(posedge ap_clk); #1;
      guard++;
    end
    check("mid_rows_accepted", 256'(n), 256'd10);
    c_if.tvalid = 1'b0; ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    check("mid_rst_qvalid", q_if.tvalid, 1'b0);
    check("mid_rst_qdata", q_if.tdata, '0);
    check("mid_rst_idle", ap_idle, 1'b1);
    check("mid_rst_done", ap_done, 1'b0);
    check("mid_rst_ctready", c_if.tready, 1'b0);

    run_job("post_rst", 7, 3, -20, 60, 100, 1'b0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
